// File: rtl/mac_sched_pkg.sv
// ---------------------------------------------------------------------------
// mac_sched_pkg
// Shared definitions for the multi-channel MAC transmit scheduler:
//   - one-hot state encoding of the scheduler FSM (9 states)
//   - default timing constants at a 125 MHz gmii_tx_clk
//   - UDP header length added to the payload length reported to mac_top
// ---------------------------------------------------------------------------
package mac_sched_pkg;

    typedef enum logic [8:0] {
        ST_IDLE      = 9'b0_0000_0001,
        ST_ARP_REQ   = 9'b0_0000_0010,
        ST_ARP_SEND  = 9'b0_0000_0100,
        ST_ARP_WAIT  = 9'b0_0000_1000,
        ST_ARB       = 9'b0_0001_0000,
        ST_GEN_REQ   = 9'b0_0010_0000,
        ST_SEND      = 9'b0_0100_0000,
        ST_GAP       = 9'b0_1000_0000,
        ST_CHECK_ARP = 9'b1_0000_0000
    } state_e;

    localparam int unsigned DEF_POWERUP_CYC      = 1250000;    // 10 ms
    localparam int unsigned DEF_ARP_RETRY_CYC    = 125000000;  // 1 s
    localparam int unsigned DEF_GAP_CYC          = 16;
    localparam int unsigned DEF_SEND_TIMEOUT_CYC = 65536;

    localparam int unsigned UDP_HDR_LEN = 8;

endpackage

// File: rtl/mac_tx_sched_if.sv
// ---------------------------------------------------------------------------
// mac_tx_sched_if
// Request/response handshake between the transmit scheduler and mac_top.
//   arp_found            mac_top -> sched  destination MAC resolved (level)
//   mac_not_exist        mac_top -> sched  ARP cache entry missing (level)
//   mac_send_end         mac_top -> sched  current frame finished (pulse)
//   arp_request_req      sched -> mac_top  ARP request (pulse)
//   udp_tx_req           sched -> mac_top  UDP send (pulse)
//   udp_send_data_length sched -> mac_top  UDP length incl. header
//   identify_code        sched -> mac_top  sequence code of granted packet
// master = scheduler side, slave = mac_top side.
// ---------------------------------------------------------------------------
interface mac_tx_sched_if;

    logic        arp_found;
    logic        mac_not_exist;
    logic        mac_send_end;
    logic        arp_request_req;
    logic        udp_tx_req;
    logic [15:0] udp_send_data_length;
    logic [15:0] identify_code;

    modport master (
        input  arp_found, mac_not_exist, mac_send_end,
        output arp_request_req, udp_tx_req, udp_send_data_length, identify_code
    );

    modport slave (
        output arp_found, mac_not_exist, mac_send_end,
        input  arp_request_req, udp_tx_req, udp_send_data_length, identify_code
    );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: returns the first requesting channel
// found when searching from ptr_i+1 upward with wrap-around.
//   req_i        per-channel request vector
//   ptr_i        index of the most recently granted channel
//   grant_o      selected channel index (0 when nothing requests)
//   any_grant_o  at least one channel requests
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_CH = 2,
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [PTR_W-1:0]  grant_o,
    output logic              any_grant_o
);

    logic [PTR_W-1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest requester
    // after the pointer is the last assignment and therefore wins.
    always_comb begin
        grant_o     = '0;
        any_grant_o = 1'b0;
        idx         = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = PTR_W'((int'(ptr_i) + k) % NUM_CH);
            if (req_i[idx]) begin
                grant_o     = idx;
                any_grant_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_tx_sched.sv
// ---------------------------------------------------------------------------
// mac_tx_sched
// Transmit scheduler for the shared UDP/ARP MAC path. After a power-up
// delay it resolves the destination MAC via ARP, then grants the MAC to one
// video channel at a time whenever that channel has a full packet buffered.
//   gmii_tx_clk     transmit clock
//   rst_n           asynchronous active-low reset
//   enable          permits new UDP grants
//   ch_level        per-channel FIFO levels, LEVEL_W bits each
//   ch_frame_start  per-channel frame-start pulse, clears sequence counter
//   mac             handshake with mac_top (mac_tx_sched_if.master)
//   grant_valid     high from the UDP request through the inter-packet gap
//   grant_ch        granted channel, steers the FIFO data/read muxes
//   send_timeout    pulse when mac_send_end never arrives
//   pkt_sent        per-channel pulse when that channel's packet completes
// ---------------------------------------------------------------------------
module mac_tx_sched
    import mac_sched_pkg::*;
#(
    parameter  int          NUM_CH           = 2,
    parameter  int          LEVEL_W          = 11,
    parameter  int          PKT_BYTES        = 1280,
    parameter  int unsigned POWERUP_CYC      = DEF_POWERUP_CYC,
    parameter  int unsigned ARP_RETRY_CYC    = DEF_ARP_RETRY_CYC,
    parameter  int unsigned GAP_CYC          = DEF_GAP_CYC,
    parameter  int unsigned SEND_TIMEOUT_CYC = DEF_SEND_TIMEOUT_CYC,
    localparam int          CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      gmii_tx_clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NUM_CH*LEVEL_W-1:0] ch_level,
    input  logic [NUM_CH-1:0]         ch_frame_start,
    mac_tx_sched_if.master            mac,
    output logic                      grant_valid,
    output logic [CH_W-1:0]           grant_ch,
    output logic                      send_timeout,
    output logic [NUM_CH-1:0]         pkt_sent
);

    localparam logic [31:0] PWR_LAST   = 32'(POWERUP_CYC - 1);
    localparam logic [31:0] RETRY_LAST = 32'(ARP_RETRY_CYC - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYC - 1);
    localparam logic [31:0] TO_LAST    = 32'(SEND_TIMEOUT_CYC - 1);
    localparam logic [15:0] UDP_LEN    = 16'(PKT_BYTES + UDP_HDR_LEN);

    state_e            state_q, state_d;
    logic [31:0]       wait_cnt_q, wait_cnt_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   grant_ch_q, grant_ch_d;
    logic [15:0]       id_code_q, id_code_d;
    logic [15:0]       udp_len_q;
    logic [15:0]       seq_q [NUM_CH];
    logic [15:0]       seq_d [NUM_CH];
    logic              seq_inc;
    logic [NUM_CH-1:0] eligible;
    logic [CH_W-1:0]   arb_grant;
    logic              arb_any;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i] = 32'(ch_level[i*LEVEL_W +: LEVEL_W]) >= 32'(PKT_BYTES);
        end
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req_i       (eligible),
        .ptr_i       (ptr_q),
        .grant_o     (arb_grant),
        .any_grant_o (arb_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_ch_d   = grant_ch_q;
        id_code_d    = id_code_q;
        seq_inc      = 1'b0;
        send_timeout = 1'b0;
        pkt_sent     = '0;
        case (state_q)
            ST_IDLE: begin
                if (wait_cnt_q == PWR_LAST) state_d = ST_ARP_REQ;
            end
            ST_ARP_REQ: state_d = ST_ARP_SEND;
            ST_ARP_SEND: begin
                if (mac.mac_send_end) begin
                    state_d = ST_ARP_WAIT;
                end else if (wait_cnt_q == TO_LAST) begin
                    send_timeout = 1'b1;
                    state_d      = ST_ARP_REQ;
                end
            end
            ST_ARP_WAIT: begin
                if (mac.arp_found)              state_d = ST_ARB;
                else if (wait_cnt_q == RETRY_LAST) state_d = ST_ARP_REQ;
            end
            ST_ARB: begin
                if (enable && arb_any) begin
                    grant_ch_d = arb_grant;
                    id_code_d  = seq_q[arb_grant];
                    state_d    = ST_GEN_REQ;
                end
            end
            ST_GEN_REQ: begin
                ptr_d   = grant_ch_q;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // Completion wins over a watchdog expiry in the same cycle.
                if (mac.mac_send_end) begin
                    pkt_sent[grant_ch_q] = 1'b1;
                    seq_inc              = 1'b1;
                    state_d              = ST_GAP;
                end else if (wait_cnt_q == TO_LAST) begin
                    send_timeout = 1'b1;
                    state_d      = ST_ARP_REQ;
                end
            end
            ST_GAP: begin
                if (wait_cnt_q == GAP_LAST) state_d = ST_CHECK_ARP;
            end
            ST_CHECK_ARP: state_d = mac.mac_not_exist ? ST_ARP_REQ : ST_ARB;
            default: state_d = ST_IDLE;
        endcase
    end

    // A frame start clears its channel's counter even if that channel is
    // completing a packet in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            seq_d[i] = seq_q[i];
            if (ch_frame_start[i])                            seq_d[i] = '0;
            else if (seq_inc && (grant_ch_q == CH_W'(i)))     seq_d[i] = seq_q[i] + 16'd1;
        end
    end

    assign wait_cnt_d = (state_d != state_q) ? '0 : wait_cnt_q + 32'd1;

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            ptr_q      <= CH_W'(NUM_CH - 1);
            grant_ch_q <= '0;
            id_code_q  <= '0;
            udp_len_q  <= UDP_LEN;
            for (int i = 0; i < NUM_CH; i++) seq_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ptr_q      <= ptr_d;
            grant_ch_q <= grant_ch_d;
            id_code_q  <= id_code_d;
            udp_len_q  <= UDP_LEN;
            for (int i = 0; i < NUM_CH; i++) seq_q[i] <= seq_d[i];
        end
    end

    assign mac.arp_request_req      = (state_q == ST_ARP_REQ);
    assign mac.udp_tx_req           = (state_q == ST_GEN_REQ);
    assign mac.udp_send_data_length = udp_len_q;
    assign mac.identify_code        = id_code_q;
    assign grant_valid = (state_q == ST_GEN_REQ) || (state_q == ST_SEND) || (state_q == ST_GAP);
    assign grant_ch    = grant_ch_q;

endmodule

// File: tb/tb_mac_tx_sched.sv
module tb_mac_tx_sched;

    localparam int NUM_CH           = 2;
    localparam int LEVEL_W          = 11;
    localparam int PKT_BYTES        = 1280;
    localparam int POWERUP_CYC      = 20;
    localparam int ARP_RETRY_CYC    = 40;
    localparam int GAP_CYC          = 16;
    localparam int SEND_TIMEOUT_CYC = 300;

    logic                      gmii_tx_clk;
    logic                      rst_n;
    logic                      enable;
    logic [NUM_CH*LEVEL_W-1:0] ch_level;
    logic [NUM_CH-1:0]         ch_frame_start;
    logic                      grant_valid;
    logic                      grant_ch;
    logic                      send_timeout;
    logic [NUM_CH-1:0]         pkt_sent;

    mac_tx_sched_if mac_if ();

    mac_tx_sched #(
        .NUM_CH           (NUM_CH),
        .LEVEL_W          (LEVEL_W),
        .PKT_BYTES        (PKT_BYTES),
        .POWERUP_CYC      (POWERUP_CYC),
        .ARP_RETRY_CYC    (ARP_RETRY_CYC),
        .GAP_CYC          (GAP_CYC),
        .SEND_TIMEOUT_CYC (SEND_TIMEOUT_CYC)
    ) dut (
        .gmii_tx_clk    (gmii_tx_clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .ch_level       (ch_level),
        .ch_frame_start (ch_frame_start),
        .mac            (mac_if),
        .grant_valid    (grant_valid),
        .grant_ch       (grant_ch),
        .send_timeout   (send_timeout),
        .pkt_sent       (pkt_sent)
    );

    initial begin
        gmii_tx_clk = 1'b0;
        forever #4 gmii_tx_clk = ~gmii_tx_clk;
    end

    int cyc = 0;
    always @(posedge gmii_tx_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct { int ch; int code; } exp_t;
    exp_t exp_q[$];

    task automatic push_exp(input int ch, input int code);
        exp_t e;
        e.ch   = ch;
        e.code = code;
        exp_q.push_back(e);
    endtask

    function automatic logic [NUM_CH*LEVEL_W-1:0] lv(input int l1, input int l0);
        return {LEVEL_W'(l1), LEVEL_W'(l0)};
    endfunction

    // Scoreboard side: every UDP request is matched against the oldest expectation.
    int udp_cnt = 0;
    int arp_cnt = 0;
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge gmii_tx_clk);
            if (mac_if.arp_request_req === 1'b1) arp_cnt++;
            if (mac_if.udp_tx_req === 1'b1) begin
                udp_cnt++;
                check("udp_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("grant_ch", 32'(grant_ch), e.ch);
                    check("identify_code", 32'(mac_if.identify_code), e.code);
                    check("grant_valid_req", 32'(grant_valid), 1);
                end
            end
        end
    end

    // which: 0 = arp_request_req, 1 = udp_tx_req, 2 = send_timeout
    task automatic wait_for(input string tag, input int which, input int budget, output int at);
        bit seen;
        seen = 1'b0;
        at   = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge gmii_tx_clk);
            case (which)
                0:       seen = (mac_if.arp_request_req === 1'b1);
                1:       seen = (mac_if.udp_tx_req === 1'b1);
                default: seen = (send_timeout === 1'b1);
            endcase
            if (seen) at = cyc;
        end
        check(tag, 32'(seen), 1);
    endtask

    // Return one mac_send_end pulse 'delay' cycles later; exp_ch < 0 means
    // no channel completion is expected.
    task automatic mac_done(input int delay, input int exp_ch, output int end_at);
        repeat (delay) @(posedge gmii_tx_clk);
        #1 mac_if.mac_send_end = 1'b1;
        @(negedge gmii_tx_clk);
        end_at = cyc;
        if (exp_ch < 0) check("pkt_sent_none", 32'(pkt_sent), 0);
        else            check("pkt_sent", 32'(pkt_sent), 32'(1) << exp_ch);
        @(posedge gmii_tx_clk);
        #1 mac_if.mac_send_end = 1'b0;
    endtask

    initial begin : watchdog
        #(20000 * 8);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t_rel, t_a, t_a2, t_g, t_e, t_t, t_x, n0;
        rst_n                = 1'b0;
        enable               = 1'b0;
        ch_level             = '0;
        ch_frame_start       = '0;
        mac_if.arp_found     = 1'b0;
        mac_if.mac_not_exist = 1'b0;
        mac_if.mac_send_end  = 1'b0;
        repeat (3) @(posedge gmii_tx_clk);
        @(negedge gmii_tx_clk);
        check("rst_arp_req", 32'(mac_if.arp_request_req), 0);
        check("rst_udp_req", 32'(mac_if.udp_tx_req), 0);
        check("rst_grant_valid", 32'(grant_valid), 0);
        check("rst_grant_ch", 32'(grant_ch), 0);
        check("rst_identify", 32'(mac_if.identify_code), 0);
        check("rst_udp_len", 32'(mac_if.udp_send_data_length), PKT_BYTES + 8);
        check("rst_timeout", 32'(send_timeout), 0);
        check("rst_pkt_sent", 32'(pkt_sent), 0);

        // Power-up, ARP, first grant to ch0
        @(posedge gmii_tx_clk);
        #1 rst_n = 1'b1;
        enable   = 1'b1;
        ch_level = lv(0, 1280);
        t_rel    = cyc;
        wait_for("arp_powerup_seen", 0, POWERUP_CYC + 20, t_a);
        check("powerup_delay", 32'(t_a - t_rel), POWERUP_CYC);
        mac_if.arp_found = 1'b1;
        push_exp(0, 0);
        mac_done(1, -1, t_e);
        wait_for("udp_first_seen", 1, 50, t_g);
        check("arp_to_udp", 32'(t_g - t_a), 4);
        check("arp_once", 32'(arp_cnt), 1);
        ch_level = lv(2000, 2000);
        mac_done(100, 0, t_e);

        // Round robin with both channels full
        for (int k = 0; k < 5; k++) begin
            int ch;
            ch = (k % 2 == 0) ? 1 : 0;
            push_exp(ch, (k + 1 - ch) / 2 + ((ch == 1) ? 0 : 0) + ((ch == 0) ? 0 : 0));
            wait_for("udp_rr_seen", 1, 200, t_g);
            check("gap_spacing", 32'(t_g - t_e), GAP_CYC + 3);
            if (k == 4) ch_level = lv(0, 1279);
            mac_done(100, ch, t_e);
            @(negedge gmii_tx_clk);
            check("grant_valid_gap", 32'(grant_valid), 1);
        end

        // Threshold: 1279 idle, 1280 granted next cycle
        n0 = udp_cnt;
        repeat (60) @(negedge gmii_tx_clk);
        check("no_grant_1279", 32'(udp_cnt - n0), 0);
        check("grant_valid_idle", 32'(grant_valid), 0);
        @(posedge gmii_tx_clk);
        #1 ch_level = lv(0, 1280);
        t_x = cyc;
        push_exp(0, 3);
        wait_for("udp_1280_seen", 1, 10, t_g);
        check("latency_1280", 32'(t_g - t_x), 1);

        // Watchdog in SEND, then retry keeps the same code
        wait_for("timeout_seen", 2, SEND_TIMEOUT_CYC + 20, t_t);
        check("timeout_delay", 32'(t_t - t_g), SEND_TIMEOUT_CYC);
        wait_for("arp_after_to_seen", 0, 5, t_a);
        check("arp_after_to", 32'(t_a - t_t), 1);
        check("grant_valid_dropped", 32'(grant_valid), 0);
        push_exp(0, 3);
        mac_done(1, -1, t_e);
        wait_for("udp_retry_seen", 1, 50, t_g);
        ch_level = lv(2000, 0);
        mac_done(100, 0, t_e);

        // ch1 codes 3,4,5; frame start coincides with the end of code 5
        for (int k = 3; k <= 5; k++) begin
            push_exp(1, k);
            wait_for("udp_ch1_seen", 1, 200, t_g);
            if (k < 5) begin
                mac_done(100, 1, t_e);
            end else begin
                repeat (100) @(posedge gmii_tx_clk);
                #1 mac_if.mac_send_end = 1'b1;
                ch_frame_start = 2'b10;
                @(negedge gmii_tx_clk);
                t_e = cyc;
                check("pkt_sent_fs", 32'(pkt_sent), 2);
                check("id_during_fs", 32'(mac_if.identify_code), 5);
                @(posedge gmii_tx_clk);
                #1 mac_if.mac_send_end = 1'b0;
                ch_frame_start = '0;
                @(negedge gmii_tx_clk);
                check("id_held_after_fs", 32'(mac_if.identify_code), 5);
            end
        end
        push_exp(1, 0);
        wait_for("udp_after_fs_seen", 1, 200, t_g);

        // mac_not_exist forces ARP before any further grant
        mac_if.mac_not_exist = 1'b1;
        mac_done(100, 1, t_e);
        n0 = udp_cnt;
        wait_for("arp_not_exist_seen", 0, GAP_CYC + 10, t_a);
        check("arp_before_udp", 32'(udp_cnt - n0), 0);
        check("arp_not_exist_delay", 32'(t_a - t_e), GAP_CYC + 2);
        mac_if.mac_not_exist = 1'b0;

        // ARP never resolves: periodic re-request
        mac_if.arp_found = 1'b0;
        mac_done(1, -1, t_x);
        wait_for("arp_retry1_seen", 0, ARP_RETRY_CYC + 10, t_a2);
        check("arp_retry1", 32'(t_a2 - t_a), ARP_RETRY_CYC + 2);
        mac_done(1, -1, t_x);
        wait_for("arp_retry2_seen", 0, ARP_RETRY_CYC + 10, t_a);
        check("arp_retry2", 32'(t_a - t_a2), ARP_RETRY_CYC + 2);

        // enable low: ARP completes, ARB holds, stray send_end ignored
        enable           = 1'b0;
        mac_if.arp_found = 1'b1;
        n0 = udp_cnt;
        mac_done(1, -1, t_x);
        mac_done(20, -1, t_x);
        repeat (20) @(negedge gmii_tx_clk);
        check("no_grant_disabled", 32'(udp_cnt - n0), 0);
        @(posedge gmii_tx_clk);
        #1 enable = 1'b1;
        t_x = cyc;
        push_exp(1, 1);
        wait_for("udp_enable_seen", 1, 10, t_g);
        check("latency_enable", 32'(t_g - t_x), 1);

        // Asynchronous reset in the middle of SEND
        repeat (10) @(posedge gmii_tx_clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_grant_valid", 32'(grant_valid), 0);
        check("midrst_grant_ch", 32'(grant_ch), 0);
        check("midrst_identify", 32'(mac_if.identify_code), 0);
        check("midrst_udp_len", 32'(mac_if.udp_send_data_length), PKT_BYTES + 8);
        check("exp_queue_empty", 32'(exp_q.size()), 0);
        repeat (2) @(posedge gmii_tx_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
